// File: rtl/mem_io_sequencer.sv
// Multi-cycle sequencer between CPU load/store/IO requests and the shared data RAM, LED and switch ports.
// The UART loader has priority over the CPU for the RAM port; the CPU is stalled until its access retires.
module mem_io_sequencer #(
  parameter int          MEM_AW  = 14,
  parameter int          MEM_LAT = 1,
  parameter logic [31:0] IO_BASE = 32'hFFFFFC00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_mread,
  input  logic              cpu_mwrite,
  input  logic              cpu_ioread,
  input  logic              cpu_iowrite,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              led_cs,
  output logic [15:0]       led_wdata,
  output logic              sw_cs,
  input  logic [15:0]       sw_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_RAM_WR,
    OP_RAM_RD,
    OP_LED_WR,
    OP_SW_RD,
    OP_IO_RD,
    OP_IO_WR,
    OP_LD_WR
  } op_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [15:0]       led_q, led_d;

  logic cpu_req;
  logic req_write;
  logic req_io;
  op_t  req_op;
  logic unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  // Flag priority only picks the direction; the region always comes from the address.
  always_comb begin
    cpu_req   = cpu_mread | cpu_mwrite | cpu_ioread | cpu_iowrite;
    req_write = cpu_mwrite | (~cpu_mread & cpu_iowrite);
    req_io    = (cpu_addr[31:10] == IO_BASE[31:10]);
    req_op    = req_write ? OP_RAM_WR : OP_RAM_RD;
    if (req_io) begin
      if (req_write) begin
        req_op = (cpu_addr[7:4] == 4'h6) ? OP_LED_WR : OP_IO_WR;
      end else begin
        req_op = (cpu_addr[7:4] == 4'h7) ? OP_SW_RD : OP_IO_RD;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    led_d     = led_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    led_cs    = 1'b0;
    sw_cs     = 1'b0;
    ld_gnt    = 1'b0;
    cpu_stall = cpu_req && (state_q != S_RESP);

    case (state_q)
      S_IDLE: begin
        if (ld_req) begin
          op_d    = OP_LD_WR;
          addr_d  = ld_addr;
          wdata_d = ld_wdata;
          state_d = S_ACCESS;
        end else if (cpu_req) begin
          op_d    = req_op;
          addr_d  = cpu_addr[MEM_AW+1:2];
          wdata_d = cpu_wdata;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        state_d = S_RESP;
        case (op_q)
          OP_RAM_WR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
          end
          OP_RAM_RD: begin
            mem_en   = 1'b1;
            mem_addr = addr_q;
            if (MEM_LAT <= 1) begin
              rdata_d = mem_rdata;
            end else begin
              cnt_d   = LAT_M1;
              state_d = S_WAIT;
            end
          end
          OP_LED_WR: begin
            led_cs = 1'b1;
            led_d  = wdata_q[15:0];
          end
          OP_SW_RD: begin
            sw_cs   = 1'b1;
            rdata_d = {16'b0, sw_rdata};
          end
          OP_IO_RD: rdata_d = '0;
          OP_IO_WR: ;
          OP_LD_WR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            ld_gnt    = 1'b1;
            state_d   = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end

      // The counter reaching zero on this decrement marks the cycle the RAM data is valid.
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      led_cs    = 1'b0;
      sw_cs     = 1'b0;
      ld_gnt    = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_IO_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign led_wdata = led_q;

endmodule

// File: tb/tb_mem_io_sequencer.sv
// Directed self-checking bench for mem_io_sequencer: one MEM_LAT=1 instance with a RAM model
// and one MEM_LAT=3 instance used for the multi-cycle read latency.
`timescale 1ns/1ps
module tb_mem_io_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        cpu_mread, cpu_mwrite, cpu_ioread, cpu_iowrite;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ld_req;
  logic [13:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        led_cs, sw_cs;
  logic [15:0] led_wdata, sw_rdata;

  logic        mread3;
  logic [31:0] addr3, cpu_rdata3, mem_wdata3, mem_rdata3;
  logic        cpu_stall3, ld_gnt3, mem_en3, mem_we3, led_cs3, sw_cs3;
  logic [13:0] mem_addr3;
  logic [15:0] led_wdata3;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram [0:16383];
  logic        hist_v1 = 1'b0, hist_v2 = 1'b0;
  logic [13:0] hist_a1 = '0, hist_a2 = '0;

  mem_io_sequencer #(.MEM_AW(14), .MEM_LAT(1), .IO_BASE(32'hFFFFFC00)) u_dut (
    .clock(clock), .reset(reset),
    .cpu_mread(cpu_mread), .cpu_mwrite(cpu_mwrite), .cpu_ioread(cpu_ioread), .cpu_iowrite(cpu_iowrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .led_cs(led_cs), .led_wdata(led_wdata), .sw_cs(sw_cs), .sw_rdata(sw_rdata)
  );

  mem_io_sequencer #(.MEM_AW(14), .MEM_LAT(3), .IO_BASE(32'hFFFFFC00)) u_dut3 (
    .clock(clock), .reset(reset),
    .cpu_mread(mread3), .cpu_mwrite(1'b0), .cpu_ioread(1'b0), .cpu_iowrite(1'b0),
    .cpu_addr(addr3), .cpu_wdata(32'h0), .cpu_rdata(cpu_rdata3), .cpu_stall(cpu_stall3),
    .ld_req(1'b0), .ld_addr(14'h0), .ld_wdata(32'h0), .ld_gnt(ld_gnt3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .led_cs(led_cs3), .led_wdata(led_wdata3), .sw_cs(sw_cs3), .sw_rdata(16'hFFFF)
  );

  // Single-cycle RAM model: read data is valid in the enable cycle.
  always @(posedge clock) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = (mem_en && !mem_we) ? ram[mem_addr] : 32'hDEAD_BEEF;

  // Three-cycle RAM model: data for word 0x123 is valid two cycles after the enable cycle.
  always @(posedge clock) begin
    hist_v1 <= mem_en3 & ~mem_we3;
    hist_a1 <= mem_addr3;
    hist_v2 <= hist_v1;
    hist_a2 <= hist_a1;
  end
  assign mem_rdata3 = (hist_v2 && hist_a2 == 14'h123) ? 32'hCAFE_F00D : 32'hDEAD_BEEF;

  task automatic applyStimulus(input logic mr, input logic mw, input logic ir, input logic iw,
                               input logic [31:0] a, input logic [31:0] d);
    cpu_mread   = mr;
    cpu_mwrite  = mw;
    cpu_ioread  = ir;
    cpu_iowrite = iw;
    cpu_addr    = a;
    cpu_wdata   = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clock);
  endtask

  initial begin
    reset    = 1'b1;
    ld_req   = 1'b0;
    ld_addr  = '0;
    ld_wdata = '0;
    sw_rdata = '0;
    mread3   = 1'b0;
    addr3    = '0;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) nextCycle();

    reset = 1'b0;
    #1;
    checkOutput("rst_stall", cpu_stall, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_rdata", cpu_rdata, 0);
    checkOutput("rst_led", led_wdata, 0);
    checkOutput("rst_gnt", ld_gnt, 0);

    // RAM write 0x1234 to byte 0x40 (word 0x10)
    nextCycle(); applyStimulus(0, 1, 0, 0, 32'h40, 32'h1234); #1;
    checkOutput("wr_idle_stall", cpu_stall, 1);
    checkOutput("wr_idle_en", mem_en, 0);
    nextCycle(); #1;
    checkOutput("wr_acc_en", mem_en, 1);
    checkOutput("wr_acc_we", mem_we, 1);
    checkOutput("wr_acc_addr", mem_addr, 32'h10);
    checkOutput("wr_acc_data", mem_wdata, 32'h1234);
    checkOutput("wr_acc_stall", cpu_stall, 1);
    nextCycle(); #1;
    checkOutput("wr_resp_stall", cpu_stall, 0);
    checkOutput("wr_resp_en", mem_en, 0);

    // RAM read back from 0x40
    nextCycle(); applyStimulus(1, 0, 0, 0, 32'h40, 32'h0); #1;
    checkOutput("rd_idle_stall", cpu_stall, 1);
    nextCycle(); #1;
    checkOutput("rd_acc_en", mem_en, 1);
    checkOutput("rd_acc_we", mem_we, 0);
    checkOutput("rd_acc_addr", mem_addr, 32'h10);
    nextCycle(); #1;
    checkOutput("rd_resp_stall", cpu_stall, 0);
    checkOutput("rd_resp_data", cpu_rdata, 32'h1234);

    // LED write
    nextCycle(); applyStimulus(0, 0, 0, 1, 32'hFFFFFC60, 32'hABCD5A5A); #1;
    checkOutput("led_idle_cs", led_cs, 0);
    nextCycle(); #1;
    checkOutput("led_acc_cs", led_cs, 1);
    checkOutput("led_acc_en", mem_en, 0);
    nextCycle(); #1;
    checkOutput("led_resp_cs", led_cs, 0);
    checkOutput("led_resp_data", led_wdata, 32'h5A5A);
    checkOutput("led_resp_stall", cpu_stall, 0);
    checkOutput("led_rdata_hold", cpu_rdata, 32'h1234);

    // Switch read
    nextCycle(); applyStimulus(0, 0, 1, 0, 32'hFFFFFC70, 32'h0); sw_rdata = 16'h00F0; #1;
    checkOutput("sw_idle_cs", sw_cs, 0);
    nextCycle(); #1;
    checkOutput("sw_acc_cs", sw_cs, 1);
    nextCycle(); #1;
    checkOutput("sw_resp_data", cpu_rdata, 32'h000000F0);
    checkOutput("sw_resp_stall", cpu_stall, 0);
    checkOutput("sw_led_hold", led_wdata, 32'h5A5A);

    // Unmapped IO read returns zero, no chip select
    nextCycle(); applyStimulus(0, 0, 1, 0, 32'hFFFFFC20, 32'h0); #1;
    nextCycle(); #1;
    checkOutput("io_acc_swcs", sw_cs, 0);
    checkOutput("io_acc_ledcs", led_cs, 0);
    checkOutput("io_acc_stall", cpu_stall, 1);
    nextCycle(); #1;
    checkOutput("io_resp_data", cpu_rdata, 0);
    checkOutput("io_resp_stall", cpu_stall, 0);

    // Loader and CPU read in the same cycle: loader first
    nextCycle(); applyStimulus(1, 0, 0, 0, 32'h80, 32'h0);
    ld_req = 1'b1; ld_addr = 14'h20; ld_wdata = 32'h55AA1234; #1;
    checkOutput("arb_idle_stall", cpu_stall, 1);
    checkOutput("arb_idle_gnt", ld_gnt, 0);
    nextCycle(); ld_req = 1'b0; #1;
    checkOutput("arb_ld_gnt", ld_gnt, 1);
    checkOutput("arb_ld_we", mem_we, 1);
    checkOutput("arb_ld_addr", mem_addr, 32'h20);
    checkOutput("arb_ld_data", mem_wdata, 32'h55AA1234);
    checkOutput("arb_ld_stall", cpu_stall, 1);
    nextCycle(); #1;
    checkOutput("arb_idle2_gnt", ld_gnt, 0);
    checkOutput("arb_idle2_en", mem_en, 0);
    checkOutput("arb_idle2_stall", cpu_stall, 1);
    nextCycle(); #1;
    checkOutput("arb_cpu_en", mem_en, 1);
    checkOutput("arb_cpu_we", mem_we, 0);
    checkOutput("arb_cpu_addr", mem_addr, 32'h20);
    nextCycle(); #1;
    checkOutput("arb_resp_data", cpu_rdata, 32'h55AA1234);
    checkOutput("arb_resp_stall", cpu_stall, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0, 32'h0); #1;
    checkOutput("arb_after_en", mem_en, 0);
    nextCycle(); #1;
    checkOutput("arb_after2_en", mem_en, 0);

    // mwrite wins over mread
    nextCycle(); applyStimulus(1, 1, 0, 0, 32'h44, 32'h77); #1;
    nextCycle(); #1;
    checkOutput("pri_acc_we", mem_we, 1);
    checkOutput("pri_acc_addr", mem_addr, 32'h11);
    nextCycle(); #1;
    checkOutput("pri_resp_stall", cpu_stall, 0);

    // mread to an IO address goes to the switches
    nextCycle(); applyStimulus(1, 0, 0, 0, 32'hFFFFFC70, 32'h0); sw_rdata = 16'h0BEE; #1;
    nextCycle(); #1;
    checkOutput("reg_acc_swcs", sw_cs, 1);
    checkOutput("reg_acc_en", mem_en, 0);
    nextCycle(); #1;
    checkOutput("reg_resp_data", cpu_rdata, 32'h00000BEE);

    // Reset held two cycles in the middle of a RAM read
    nextCycle(); applyStimulus(1, 0, 0, 0, 32'h40, 32'h0); #1;
    nextCycle(); reset = 1'b1; #1;
    checkOutput("mrst_acc_en", mem_en, 0);
    checkOutput("mrst_acc_stall", cpu_stall, 0);
    nextCycle(); #1;
    checkOutput("mrst_r2_en", mem_en, 0);
    checkOutput("mrst_r2_rdata", cpu_rdata, 0);
    nextCycle(); reset = 1'b0; #1;
    checkOutput("mrst_idle_en", mem_en, 0);
    checkOutput("mrst_idle_rdata", cpu_rdata, 0);
    checkOutput("mrst_idle_led", led_wdata, 0);
    checkOutput("mrst_idle_stall", cpu_stall, 1);
    nextCycle(); #1;
    checkOutput("mrst_acc2_en", mem_en, 1);
    nextCycle(); #1;
    checkOutput("mrst_resp_data", cpu_rdata, 32'h1234);
    checkOutput("mrst_resp_stall", cpu_stall, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);

    // MEM_LAT=3 read of word 0x123 retires in five cycles
    nextCycle(); mread3 = 1'b1; addr3 = 32'h0000048C; #1;
    checkOutput("l3_idle_stall", cpu_stall3, 1);
    nextCycle(); #1;
    checkOutput("l3_acc_en", mem_en3, 1);
    checkOutput("l3_acc_addr", mem_addr3, 32'h123);
    checkOutput("l3_acc_we", mem_we3, 0);
    nextCycle(); #1;
    checkOutput("l3_w1_stall", cpu_stall3, 1);
    checkOutput("l3_w1_en", mem_en3, 0);
    nextCycle(); #1;
    checkOutput("l3_w2_stall", cpu_stall3, 1);
    nextCycle(); #1;
    checkOutput("l3_resp_stall", cpu_stall3, 0);
    checkOutput("l3_resp_data", cpu_rdata3, 32'hCAFEF00D);
    checkOutput("l3_gnt", ld_gnt3, 0);
    checkOutput("l3_ledcs", led_cs3, 0);
    checkOutput("l3_swcs", sw_cs3, 0);
    checkOutput("l3_led", led_wdata3, 0);
    checkOutput("l3_wdata", mem_wdata3, 0);
    nextCycle(); mread3 = 1'b0; #1;
    checkOutput("l3_after_stall", cpu_stall3, 0);
    checkOutput("l3_after_hold", cpu_rdata3, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
